// File: rtl/shift_tx_sequencer.sv
// Drives the Load/ShiftR controls of a WIDTH-bit shift register so that each
// accepted byte leaves its data_out MSB first, one bit every CLKS_PER_BIT cycles.
module shift_tx_sequencer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     tx_valid,
    input  logic [WIDTH-1:0]         tx_data,
    output logic                     tx_ready,
    output logic                     Load,
    output logic                     ShiftR,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     sr_fill,
    output logic                     frame,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [GW-1:0]    gap_q;
    logic [WIDTH-1:0] par_q;
    logic             rdy_q, load_q, shr_q, frame_q, done_q;

    logic             cnt_last, bit_last, shr_d;
    logic [CW-1:0]    cnt_d;
    logic [BW-1:0]    bit_d;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign bit_last = (bit_q == BIT_LAST);
    assign cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    // Bit index holds at WIDTH-1 so it never wraps inside a frame.
    assign bit_d    = (cnt_last && !bit_last) ? bit_q + 1'b1 : bit_q;
    // Strobe for the next SHIFT cycle: last cycle of any bit period but the final one.
    assign shr_d    = (cnt_d == CNT_LAST) && (bit_d != BIT_LAST);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            par_q   <= '0;
            rdy_q   <= 1'b1;
            load_q  <= 1'b0;
            shr_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            shr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        par_q   <= tx_data;
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                    frame_q <= 1'b1;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    shr_q   <= (CNT_LAST == '0) && (BIT_LAST != '0);
                end
                SHIFT: begin
                    if (cnt_last && bit_last) begin
                        frame_q <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b1;
                        end else begin
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        bit_q <= bit_d;
                        shr_q <= shr_d;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    frame_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = rdy_q;
    assign Load         = load_q;
    assign ShiftR       = shr_q;
    assign parallel_out = par_q;
    assign sr_fill      = 1'b0;
    assign frame        = frame_q;
    assign bit_idx      = bit_q;
    assign done         = done_q;
endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Two sequencer configurations (CPB=2/GAP=1 and CPB=1/GAP=0) share one stimulus
// stream; a timing model and a serial-bit scoreboard check each of them.
module tb_shift_tx_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int CPB = (g == 0) ? 2 : 1;
        localparam int GAP = (g == 0) ? 1 : 0;
        localparam int FC  = W * CPB;
        localparam int P   = 1 + FC + GAP;  // busy cycles after a handshake edge

        logic         rdy, ld, sr, fr, dn, fill;
        logic [W-1:0] po;
        logic [2:0]   bi;

        shift_tx_sequencer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP)) u_dut (
            .clk(clk), .Reset(Reset), .tx_valid(tx_valid), .tx_data(tx_data),
            .tx_ready(rdy), .Load(ld), .ShiftR(sr), .parallel_out(po),
            .sr_fill(fill), .frame(fr), .bit_idx(bi), .done(dn)
        );

        // Downstream Load/ShiftR register whose MSB is data_out.
        logic [W-1:0] sreg;
        always @(posedge clk) begin
            if (ld) sreg <= po;
            else if (sr) sreg <= {sreg[W-2:0], fill};
        end

        // Reference: everything follows from cycles elapsed since the last handshake.
        bit           active;
        int           age;
        logic [W-1:0] last = '0;
        bit           q[$];
        logic         exp_rdy;
        assign exp_rdy = !(active && age <= P);

        always @(posedge clk or posedge Reset) begin
            if (Reset) begin
                active <= 1'b0;
                age    <= 0;
                last   <= '0;
                q.delete();
            end else if (tx_valid && exp_rdy) begin
                active <= 1'b1;
                age    <= 1;
                last   <= tx_data;
                for (int i = W - 1; i >= 0; i--)
                    for (int k = 0; k < CPB; k++) q.push_back(tx_data[i]);
            end else if (active && age <= P + 1) begin
                age <= age + 1;
            end
        end

        always @(negedge clk) begin
            int fi;
            bit ef;
            fi = age - 2;
            ef = active && fi >= 0 && fi < FC;
            chk($sformatf("tx_ready[%0d]", g), rdy, exp_rdy);
            chk($sformatf("Load[%0d]", g), ld, active && age == 1);
            chk($sformatf("frame[%0d]", g), fr, ef);
            chk($sformatf("ShiftR[%0d]", g), sr, ef && ((fi + 1) % CPB == 0) && (fi / CPB < W - 1));
            chk($sformatf("done[%0d]", g), dn, active && age == FC + 2);
            chk($sformatf("parallel_out[%0d]", g), po, last);
            chk($sformatf("sr_fill[%0d]", g), fill, 0);
            if (ef) chk($sformatf("bit_idx[%0d]", g), bi, fi / CPB);
            if (fr) begin
                if (q.size() == 0) chk($sformatf("serial_underrun[%0d]", g), 1, 0);
                else chk($sformatf("data_out[%0d]", g), sreg[W-1], q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic chk_rst(input string nm, input logic r, l, s, f, d,
                           input logic [W-1:0] p, input logic [2:0] b);
        chk({nm, "_ready"}, r, 1);
        chk({nm, "_load"}, l, 0);
        chk({nm, "_shiftr"}, s, 0);
        chk({nm, "_frame"}, f, 0);
        chk({nm, "_done"}, d, 0);
        chk({nm, "_pout"}, p, 0);
        chk({nm, "_bitidx"}, b, 0);
    endtask

    initial begin
        int t1, t2;
        bit ok;
        // Reset held with a pending byte: nothing may be taken.
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        idle(4);
        chk_rst("rst0", gi[0].rdy, gi[0].ld, gi[0].sr, gi[0].fr, gi[0].dn, gi[0].po, gi[0].bi);
        chk_rst("rst1", gi[1].rdy, gi[1].ld, gi[1].sr, gi[1].fr, gi[1].dn, gi[1].po, gi[1].bi);
        tx_valid = 1'b0;
        Reset    = 1'b0;
        idle(2);

        send(8'hA5);
        idle(40);

        // Back-to-back with valid held: Load spacing on the CPB=2 instance.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        t1 = 0; t2 = 0; ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            if (gi[0].ld) begin t1 = cyc; ok = 1'b1; end
        end
        if (!ok) chk("wait_first_load", 0, 1);
        tx_data = 8'hC3;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            if (gi[0].ld) begin t2 = cyc; ok = 1'b1; end
        end
        if (!ok) chk("wait_second_load", 0, 1);
        chk("load_spacing", t2 - t1, 19);
        tx_valid = 1'b0;
        idle(40);

        // Async reset in the middle of bit 3.
        send(8'h96);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            if (gi[0].fr && gi[0].bi == 3'd3) ok = 1'b1;
        end
        if (!ok) chk("wait_bit3", 0, 1);
        #2 Reset = 1'b1;
        #1;
        chk_rst("midrst0", gi[0].rdy, gi[0].ld, gi[0].sr, gi[0].fr, gi[0].dn, gi[0].po, gi[0].bi);
        chk_rst("midrst1", gi[1].rdy, gi[1].ld, gi[1].sr, gi[1].fr, gi[1].dn, gi[1].po, gi[1].bi);
        @(posedge clk);
        #1 Reset = 1'b0;
        idle(1);
        send(8'hFF);
        idle(40);

        // Valid pulse while shifting is ignored.
        send(8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (gi[0].fr) ok = 1'b1;
            else idle(1);
        end
        if (!ok) chk("wait_frame", 0, 1);
        send(8'h00);
        chk("pout_hold", gi[0].po, 8'h5A);
        idle(40);

        repeat (400) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = W'($urandom);
            idle(1);
        end
        tx_valid = 1'b0;
        idle(40);

        chk("serial_leftover0", gi[0].q.size(), 0);
        chk("serial_leftover1", gi[1].q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
